// File: rtl/apb_master.sv
// apb_master: single-outstanding APB3/APB4 initiator turning host commands into APB transfers with one response each
module apb_master #(
    parameter int DW      = 8,
    parameter int BW      = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [BW-1:0]    cmd_wdata_i,
    input  logic [BW/DW-1:0] cmd_strb_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [BW-1:0]    rsp_rdata_o,
    output logic             rsp_err_o,
    output logic             rsp_timeout_o,
    output logic             psel_o,
    output logic             penable_o,
    output logic             pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [BW-1:0]    pwdata_o,
    output logic [BW/DW-1:0] pstrb_o,
    input  logic             pready_i,
    input  logic [BW-1:0]    prdata_i,
    input  logic             pslverr_i
);
    localparam int CW = $clog2(TIMEOUT + 2);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic           w_accept;
    logic           w_tmo;
    logic           w_exit;
    assign cmd_ready_o = (r_state == IDLE) && !reset_i;
    assign w_accept    = cmd_valid_i && cmd_ready_o;
    assign w_tmo       = (TIMEOUT != 0) && !pready_i && (r_cnt + CW'(1) == CW'(TIMEOUT));
    assign w_exit      = (r_state == ACCESS) && (pready_i || w_tmo);
    // state register
    always_ff @(posedge clk_i) r_state <= reset_i ? IDLE : w_next;
    // next-state: a ready slave in the same cycle as the timeout completes normally
    always_comb begin
        w_next = r_state;
        w_next = w_accept ? SETUP :
                 (r_state == SETUP) ? ACCESS :
                 w_exit ? RESP :
                 (r_state == RESP && rsp_ready_i) ? IDLE : r_state;
    end
    // registered APB drive, wait counter and response capture; the APB regs double as the latched command
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            r_cnt         <= '0;
        end else begin
            if (w_accept) begin
                psel_o    <= 1'b1;
                penable_o <= 1'b0;
                pwrite_o  <= cmd_write_i;
                paddr_o   <= cmd_addr_i;
                pwdata_o  <= cmd_write_i ? cmd_wdata_i : '0;
                pstrb_o   <= cmd_write_i ? cmd_strb_i : '0;
            end
            if (r_state == SETUP) penable_o <= 1'b1;
            if (r_state == ACCESS) r_cnt <= w_exit ? '0 : r_cnt + CW'(1);
            if (w_exit) begin
                psel_o        <= 1'b0;
                penable_o     <= 1'b0;
                rsp_valid_o   <= 1'b1;
                rsp_rdata_o   <= (pready_i && !pwrite_o) ? prdata_i : '0;
                rsp_err_o     <= pready_i ? pslverr_i : 1'b1;
                rsp_timeout_o <= !pready_i;
            end
            if (r_state == RESP && rsp_ready_i) rsp_valid_o <= 1'b0;
        end
    end
endmodule
